// File: rtl/vga_timing_generator.sv
// rtl/vga_timing_generator.sv - registered raster timing core (counters, syncs, DE, strobes)
module vga_timing_generator #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        EN,
    output logic [10:0] HCNT,
    output logic [10:0] VCNT,
    output logic        HS,
    output logic        VS,
    output logic        DE,
    output logic        VBLANK,
    output logic        LINE_START,
    output logic        FRAME_START
);

    localparam logic [10:0] H_MAX      = 11'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [10:0] V_MAX      = 11'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [10:0] H_VIS      = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS      = 11'(V_VISIBLE);
    localparam logic [10:0] HS_START   = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END     = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_START   = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END     = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [10:0] hcnt_q, hcnt_d;
    logic [10:0] vcnt_q, vcnt_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        de_q, de_d;
    logic        vblank_q, vblank_d;
    logic        line_start_q, line_start_d;
    logic        frame_start_q, frame_start_d;

    logic h_last, v_last;

    assign h_last = (hcnt_q == H_MAX);
    assign v_last = (vcnt_q == V_MAX);

    // Decode from the next counts so syncs/DE line up with the counters they accompany.
    always_comb begin
        hcnt_d        = hcnt_q;
        vcnt_d        = vcnt_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (EN) begin
            hcnt_d       = h_last ? 11'd0 : hcnt_q + 11'd1;
            line_start_d = h_last;
            if (h_last) begin
                vcnt_d        = v_last ? 11'd0 : vcnt_q + 11'd1;
                frame_start_d = v_last;
            end
        end
        hs_d     = ((hcnt_d >= HS_START) && (hcnt_d < HS_END)) ? H_SYNC_POL : ~H_SYNC_POL;
        vs_d     = ((vcnt_d >= VS_START) && (vcnt_d < VS_END)) ? V_SYNC_POL : ~V_SYNC_POL;
        de_d     = (hcnt_d < H_VIS) && (vcnt_d < V_VIS);
        vblank_d = (vcnt_d >= V_VIS);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hcnt_q        <= H_MAX;
            vcnt_q        <= V_MAX;
            hs_q          <= ~H_SYNC_POL;
            vs_q          <= ~V_SYNC_POL;
            de_q          <= 1'b0;
            vblank_q      <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            de_q          <= de_d;
            vblank_q      <= vblank_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign HCNT        = hcnt_q;
    assign VCNT        = vcnt_q;
    assign HS          = hs_q;
    assign VS          = vs_q;
    assign DE          = de_q;
    assign VBLANK      = vblank_q;
    assign LINE_START  = line_start_q;
    assign FRAME_START = frame_start_q;

endmodule
